// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - framed UART message transmitter (8N1, LSB first, opt/len/data bytes)
module uart_tx #(
    parameter int BYTE_SIZE    = 8,
    parameter int BIT_CLKS     = 16,
    parameter int MAX_MSG_LEN  = (1 << BYTE_SIZE) - 1,
    parameter int DATA_BYTES   = $clog2(MAX_MSG_LEN),
    parameter int IN_DATA_SIZE = DATA_BYTES * BYTE_SIZE
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [BYTE_SIZE-1:0]    i_opt,
    input  logic [BYTE_SIZE-1:0]    i_len,
    input  logic [IN_DATA_SIZE-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_tx_bit,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int TIMER_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int BIT_W   = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
    localparam int IDX_W   = $clog2(DATA_BYTES + 2) + 1;
    localparam int DSEL_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    localparam logic [BYTE_SIZE-1:0] DATA_BYTES_B = BYTE_SIZE'(DATA_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Bit timer and position counters
    logic [TIMER_W-1:0]   timer;
    logic [BIT_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     byte_idx;
    logic [IDX_W-1:0]     len_idx;

    // Byte currently on the line, shifted right as bits go out
    logic [BYTE_SIZE-1:0] shreg;

    // Latched payload, one entry per data byte
    logic [BYTE_SIZE-1:0] data_arr [DATA_BYTES];

    // Registered line and completion pulse, plus their next values
    logic                 tx_q;
    logic                 tx_next;
    logic                 done_q;
    logic                 done_next;
    logic                 ready;

    // Derived control terms
    logic                 bit_end;
    logic                 last_bit;
    logic                 last_byte;
    logic [BYTE_SIZE-1:0] eff_len;
    logic [BYTE_SIZE-1:0] len_byte;
    logic [IDX_W-1:0]     next_idx;
    logic [DSEL_W-1:0]    dsel;
    logic [BYTE_SIZE-1:0] next_byte;

    assign bit_end   = (timer == TIMER_W'(BIT_CLKS - 1));
    assign last_bit  = (bit_idx == BIT_W'(BYTE_SIZE - 1));
    // Byte index runs 0 (opt), 1 (len), 2..len+1 (data), so the last one is len+1
    assign last_byte = (byte_idx == len_idx + IDX_W'(1));

    // Oversized lengths saturate to the payload capacity; the saturated value is what goes on the wire
    assign eff_len   = (i_len > DATA_BYTES_B) ? DATA_BYTES_B : i_len;
    assign len_byte  = BYTE_SIZE'(len_idx);

    // Byte to load at the end of a stop bit when more bytes follow
    assign next_idx  = byte_idx + IDX_W'(1);
    assign dsel      = DSEL_W'(next_idx - IDX_W'(2));
    assign next_byte = (next_idx == IDX_W'(1)) ? len_byte : data_arr[dsel];

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic: start, data bits, stop, then next byte or idle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_valid)              next_state = START;
            START:   if (bit_end)              next_state = DATA;
            DATA:    if (bit_end && last_bit)  next_state = STOP;
            STOP:    if (bit_end)              next_state = last_byte ? IDLE : START;
            default:                           next_state = IDLE;
        endcase
    end

    // FSM outputs: handshake flags and the next value of the registered line
    always_comb begin
        ready     = (state == IDLE);
        tx_next   = tx_q;
        done_next = 1'b0;
        case (state)
            // An accept drives the start bit on the very next cycle
            IDLE:  tx_next = ~i_valid;
            START: if (bit_end) tx_next = shreg[0];
            DATA:  if (bit_end) tx_next = last_bit ? 1'b1 : shreg[1];
            STOP: begin
                if (bit_end) begin
                    // Last byte returns the line to idle; otherwise the next start bit begins
                    tx_next   = last_byte;
                    done_next = last_byte;
                end
            end
            default: tx_next = 1'b1;
        endcase
    end

    // Line and completion registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_next;
            done_q <= done_next;
        end
    end

    // Datapath: message latch, bit timer, bit/byte counters and shift register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            len_idx  <= '0;
            shreg    <= '0;
            for (int k = 0; k < DATA_BYTES; k++) begin
                data_arr[k] <= '0;
            end
        end else begin
            // Timer is held at zero while idle so every message starts on a clean bit phase
            if (state == IDLE || bit_end) begin
                timer <= '0;
            end else begin
                timer <= timer + TIMER_W'(1);
            end

            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shreg    <= i_opt;
                        len_idx  <= IDX_W'(eff_len);
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        for (int k = 0; k < DATA_BYTES; k++) begin
                            data_arr[k] <= i_data[k*BYTE_SIZE +: BYTE_SIZE];
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= last_bit ? '0 : bit_idx + BIT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end && !last_byte) begin
                        byte_idx <= next_idx;
                        shreg    <= next_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready  = ready;
    assign o_busy   = ~ready;
    assign o_tx_bit = tx_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: serial decode monitor plus done-timing monitor
module tb_uart_tx;

    localparam int BIT_CLKS = 16;

    logic        CLK;
    logic        RST;
    logic [7:0]  i_opt;
    logic [7:0]  i_len;
    logic [63:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_tx_bit;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] byte_q [$];
    int         done_q [$];

    uart_tx dut (
        .CLK     (CLK),
        .RST     (RST),
        .i_opt   (i_opt),
        .i_len   (i_len),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_tx_bit(o_tx_bit),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial decode: find start bit, sample mid-bit, compare byte against the expected queue
    initial begin : byte_mon
        logic [7:0] b;
        bit         abort;
        forever begin
            @(negedge CLK);
            if (!RST && o_tx_bit === 1'b0) begin
                abort = 1'b0;
                b     = '0;
                repeat (BIT_CLKS / 2 - 1) begin
                    @(negedge CLK);
                    if (RST) abort = 1'b1;
                end
                if (!abort) check("start_bit", o_tx_bit, 1'b0);
                for (int i = 0; i < 8 && !abort; i++) begin
                    repeat (BIT_CLKS) begin
                        @(negedge CLK);
                        if (RST) abort = 1'b1;
                    end
                    b[i] = o_tx_bit;
                end
                if (!abort) begin
                    repeat (BIT_CLKS) begin
                        @(negedge CLK);
                        if (RST) abort = 1'b1;
                    end
                end
                if (!abort) begin
                    check("stop_bit", o_tx_bit, 1'b1);
                    if (byte_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL byte_unexpected: got %0h expected no byte (cycle %0d)", b, cyc);
                    end else begin
                        check("byte", b, byte_q.pop_front());
                    end
                end
            end
        end
    end

    // Completion monitor: each o_done pulse must land on its expected cycle
    initial begin : done_mon
        forever begin
            @(negedge CLK);
            if (o_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("done_ready_busy", {o_ready, o_busy}, 2'b10);
                end
            end
        end
    end

    // Issue one message; exp holds the n expected line bytes, first byte leftmost
    task automatic send(input logic [7:0] opt, input logic [7:0] len, input logic [63:0] data,
                        input logic [79:0] exp, input int n, input int frame_cycles,
                        input bit hold_valid, output int acc);
        int waited;
        @(negedge CLK);
        i_opt   = opt;
        i_len   = len;
        i_data  = data;
        i_valid = 1'b1;
        waited  = 0;
        while (o_ready !== 1'b1 && waited < 3000) begin
            @(negedge CLK);
            waited++;
        end
        if (o_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got o_ready=%b expected 1", o_ready);
            i_valid = 1'b0;
            acc     = -1;
            return;
        end
        acc = cyc;
        for (int i = 0; i < n; i++) byte_q.push_back(exp[(n-1-i)*8 +: 8]);
        done_q.push_back(acc + 1 + frame_cycles);
        @(negedge CLK);
        check("accept_outputs", {o_ready, o_busy, o_tx_bit}, 3'b010);
        if (!hold_valid) i_valid = 1'b0;
    endtask

    task automatic wait_done();
        int waited;
        waited = 0;
        while (done_q.size() != 0 && waited < 5000) begin
            @(negedge CLK);
            waited++;
        end
        if (done_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d pending expected 0", done_q.size());
            done_q.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc_a;
        int acc_b;
        int acc;
        int target;

        RST     = 1'b1;
        i_opt   = '0;
        i_len   = '0;
        i_data  = '0;
        i_valid = 1'b0;

        // Reset state and idle line
        repeat (3) @(negedge CLK);
        check("reset_outputs", {o_tx_bit, o_ready, o_busy, o_done}, 4'b1100);
        RST = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            check("idle_outputs", {o_tx_bit, o_ready, o_busy, o_done}, 4'b1100);
        end

        // Two data bytes
        send(8'hA5, 8'd2, 64'h3C01, 80'hA5_02_01_3C, 4, 640, 1'b0, acc);
        wait_done();

        // Zero length: only opt and len
        send(8'h7E, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 80'h7E_00, 2, 320, 1'b0, acc);
        wait_done();

        // Oversized length saturates to 8
        send(8'hC3, 8'd20, 64'h0123_4567_89AB_CDEF, 80'hC3_08_EF_CD_AB_89_67_45_23_01, 10, 1600, 1'b0, acc);
        wait_done();

        // Back-to-back with i_valid held high and inputs changed mid-frame
        send(8'h11, 8'd1, 64'h55, 80'h11_01_55, 3, 480, 1'b1, acc_a);
        repeat (20) @(negedge CLK);
        i_opt  = 8'hFF;
        i_len  = 8'd8;
        i_data = 64'hAAAA_AAAA_AAAA_AAAA;
        repeat (100) @(negedge CLK);
        send(8'h22, 8'd3, 64'hC3B2A1, 80'h22_03_A1_B2_C3, 5, 800, 1'b0, acc_b);
        check("b2b_accept_cycle", acc_b, acc_a + 1 + 480);
        wait_done();

        // Reset during bit 3 of data byte 0 (data byte 0 = F0, so that bit is 0)
        send(8'h5A, 8'd1, 64'hF0, 80'h5A_01_F0, 3, 480, 1'b0, acc);
        target = acc + 1 + 2 * 10 * BIT_CLKS + 4 * BIT_CLKS + BIT_CLKS / 2;
        while (cyc < target) @(negedge CLK);
        check("pre_reset_line", o_tx_bit, 1'b0);
        #2;
        RST = 1'b1;
        byte_q.delete();
        done_q.delete();
        #1;
        check("reset_async", {o_tx_bit, o_ready, o_busy, o_done}, 4'b1100);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (50) @(negedge CLK);
        check("post_reset_idle", {o_tx_bit, o_ready, o_busy, o_done}, 4'b1100);

        // Fresh message after reset
        send(8'h96, 8'd2, 64'hBEEF, 80'h96_02_EF_BE, 4, 640, 1'b0, acc);
        wait_done();

        check("bytes_left", byte_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
